// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Hold counter is wide enough for the largest supported MAX_HOLD.
  localparam int unsigned HOLD_W   = 8;
  localparam int unsigned HOLD_MIN = 1;
  localparam int unsigned HOLD_CAP = 255;

  // Response tag carried alongside each accepted command.
  typedef struct packed {
    logic rd;
    logic id;
  } tag_t;

  // Clamp a requested hold limit into the range the counter supports.
  function automatic int unsigned hold_limit(input int unsigned max_hold);
    if (max_hold < HOLD_MIN) return HOLD_MIN;
    if (max_hold > HOLD_CAP) return HOLD_CAP;
    return max_hold;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with an optional bounded lock for the current owner.
module rr_arb2
  import bram_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic a_lock,
  input  logic b_valid,
  input  logic b_lock,
  output logic grant_a,
  output logic grant_b
);

  localparam int unsigned      HOLD_LIM = hold_limit(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIM);

  logic              prio_q, prio_d;
  logic              lock_vld_q, lock_vld_d;
  logic              lock_id_q, lock_id_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              gnt_vld;
  logic              gnt_id;
  logic              owner_valid;
  logic              other_valid;
  logic              gnt_lock;
  logic              gnt_other_valid;
  logic [HOLD_W-1:0] hold_base;

  // Grant selection: a live lock wins unless it has used up its hold budget.
  always_comb begin
    owner_valid = (lock_id_q == REQ_A) ? a_valid : b_valid;
    other_valid = (lock_id_q == REQ_A) ? b_valid : a_valid;
    gnt_vld     = a_valid | b_valid;
    gnt_id      = REQ_A;
    if (lock_vld_q && owner_valid) begin
      gnt_id = (other_valid && (hold_q == HOLD_MAX)) ? ~lock_id_q : lock_id_q;
    end else if (a_valid && !b_valid) begin
      gnt_id = REQ_A;
    end else if (b_valid && !a_valid) begin
      gnt_id = REQ_B;
    end else begin
      gnt_id = prio_q;
    end
  end

  assign grant_a = gnt_vld && (gnt_id == REQ_A);
  assign grant_b = gnt_vld && (gnt_id == REQ_B);

  // Next pointer, lock owner and hold count after this cycle's grant.
  always_comb begin
    prio_d          = prio_q;
    lock_vld_d      = lock_vld_q;
    lock_id_d       = lock_id_q;
    hold_d          = hold_q;
    gnt_lock        = (gnt_id == REQ_A) ? a_lock : b_lock;
    gnt_other_valid = (gnt_id == REQ_A) ? b_valid : a_valid;
    hold_base       = (lock_vld_q && (lock_id_q == gnt_id)) ? hold_q : '0;
    if (gnt_vld) begin
      prio_d = ~gnt_id;
      if (gnt_lock) begin
        lock_vld_d = 1'b1;
        lock_id_d  = gnt_id;
        // Only contested grants consume the hold budget.
        hold_d     = (gnt_other_valid && (hold_base != HOLD_MAX)) ?
                     hold_base + HOLD_W'(1) : hold_base;
      end else begin
        lock_vld_d = 1'b0;
        hold_d     = '0;
      end
    end else begin
      // No grant means the owner (if any) dropped valid.
      lock_vld_d = 1'b0;
      hold_d     = '0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= REQ_A;
      lock_vld_q <= 1'b0;
      lock_id_q  <= REQ_A;
      hold_q     <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between a host loader (A) and a compute engine (B).
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic grant_a;
  logic grant_b;

  rr_arb2 #(
    .MAX_HOLD(MAX_HOLD)
  ) u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .a_valid(a_valid),
    .a_lock (a_lock),
    .b_valid(b_valid),
    .b_lock (b_lock),
    .grant_a(grant_a),
    .grant_b(grant_b)
  );

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  logic              xfer;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  tag_t              tag_d;

  // Select the granted requester's command fields and build its response tag.
  always_comb begin
    xfer      = grant_a | grant_b;
    cmd_we    = grant_b ? b_we    : a_we;
    cmd_addr  = grant_b ? b_addr  : a_addr;
    cmd_wdata = grant_b ? b_wdata : a_wdata;
    tag_d.rd  = xfer & ~cmd_we;
    tag_d.id  = grant_b ? REQ_B : REQ_A;
  end

  logic              mem_ce_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Command stage: registered BRAM port; address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_ce_q <= xfer;
      mem_we_q <= xfer & cmd_we;
      if (xfer) begin
        mem_addr_q  <= cmd_addr;
        mem_wdata_q <= cmd_wdata;
      end
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  tag_t tag_q;
  logic a_rvalid_q;
  logic b_rvalid_q;

  // Tag pipeline: stage one follows the command, stage two is the demuxed rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      a_rvalid_q <= tag_q.rd && (tag_q.id == REQ_A);
      b_rvalid_q <= tag_q.rd && (tag_q.id == REQ_B);
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  // BRAM output register already aligns with the rvalid pulse.
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a transaction-level reference model.
module tb_bram_port_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 10;
  localparam int          MAXH = 4;
  localparam int          LOGN = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_valid = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .MAX_HOLD(MAXH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_we     (a_we),
    .a_lock   (a_lock),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_we     (b_we),
    .b_lock   (b_lock),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Background contents of every untouched location.
  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE0000 + 32'(a);
  endfunction

  // Behavioural single-port BRAM with registered read data.
  logic [DW-1:0] bram    [1024];
  bit            bram_wr [1024];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        bram[mem_addr]    <= mem_wdata;
        bram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= bram_wr[mem_addr] ? bram[mem_addr] : pat(int'(mem_addr));
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle record of what the DUT did, for the hand-computed checks.
  int            log_gnt   [LOGN];
  bit            log_arv   [LOGN];
  bit            log_brv   [LOGN];
  bit            log_mwe   [LOGN];
  logic [DW-1:0] log_rdata [LOGN];

  logic [DW-1:0] ref_mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model plus per-cycle comparison of every DUT output.
  task automatic compare_loop();
    int            m_prio, m_owner, m_streak, g;
    bit            v [2];
    bit            lk [2];
    bit            wq [2];
    int            ad [2];
    logic [DW-1:0] wd [2];
    bit            e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            p1_v, p2_v;
    int            p1_id, p2_id;
    logic [DW-1:0] p1_d, p2_d;
    m_prio = 0; m_owner = -1; m_streak = 0;
    e_ce = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    p1_v = 0; p2_v = 0; p1_id = 0; p2_id = 0; p1_d = '0; p2_d = '0;
    forever begin
      @(negedge clk);
      if (cyc < LOGN) begin
        log_gnt[cyc]   = b_ready ? 2 : (a_ready ? 1 : 0);
        log_arv[cyc]   = a_rvalid;
        log_brv[cyc]   = b_rvalid;
        log_mwe[cyc]   = mem_we;
        log_rdata[cyc] = a_rvalid ? a_rdata : b_rdata;
      end
      if (rst) begin
        check("rst_mem_ce", 32'(mem_ce), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_a_rvalid", 32'(a_rvalid), 32'(0));
        check("rst_b_rvalid", 32'(b_rvalid), 32'(0));
        m_prio = 0; m_owner = -1; m_streak = 0;
        e_ce = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        p1_v = 0; p2_v = 0;
      end else begin
        v[0] = a_valid; v[1] = b_valid; lk[0] = a_lock; lk[1] = b_lock;
        wq[0] = a_we; wq[1] = b_we; ad[0] = int'(a_addr); ad[1] = int'(b_addr);
        wd[0] = a_wdata; wd[1] = b_wdata;
        if (m_owner >= 0 && v[m_owner])
          g = (v[1-m_owner] && m_streak >= MAXH) ? 1 - m_owner : m_owner;
        else if (v[0] && v[1]) g = m_prio;
        else if (v[0]) g = 0;
        else if (v[1]) g = 1;
        else g = -1;

        check("a_ready", 32'(a_ready), 32'(g == 0));
        check("b_ready", 32'(b_ready), 32'(g == 1));
        check("mem_ce", 32'(mem_ce), 32'(e_ce));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("a_rvalid", 32'(a_rvalid), 32'(p2_v && p2_id == 0));
        check("b_rvalid", 32'(b_rvalid), 32'(p2_v && p2_id == 1));
        if (p2_v && p2_id == 0) check("a_rdata", a_rdata, p2_d);
        if (p2_v && p2_id == 1) check("b_rdata", b_rdata, p2_d);

        p2_v = p1_v; p2_id = p1_id; p2_d = p1_d;
        if (g >= 0) begin
          e_ce = 1; e_we = wq[g]; e_addr = AW'(ad[g]); e_wdata = wd[g];
          if (wq[g]) ref_mem[ad[g]] = wd[g];
          p1_v  = !wq[g];
          p1_id = g;
          p1_d  = ref_mem.exists(ad[g]) ? ref_mem[ad[g]] : pat(ad[g]);
          m_prio = 1 - g;
          if (lk[g]) begin
            if (m_owner != g) m_streak = 0;
            m_owner = g;
            if (v[1-g] && m_streak < MAXH) m_streak++;
          end else begin
            m_owner = -1; m_streak = 0;
          end
        end else begin
          e_ce = 0; e_we = 0; p1_v = 0;
          m_owner = -1; m_streak = 0;
        end
      end
    end
  endtask

  // Apply one cycle of requester inputs; t is the cycle they are presented in.
  task automatic drive(input bit av, input bit awe, input bit alk, input int aad,
                       input logic [DW-1:0] awd,
                       input bit bv, input bit bwe, input bit blk, input int bad,
                       input logic [DW-1:0] bwd, output int t);
    a_valid = av; a_we = awe; a_lock = alk; a_addr = AW'(aad); a_wdata = awd;
    b_valid = bv; b_we = bwe; b_lock = blk; b_addr = AW'(bad); b_wdata = bwd;
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    int t;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, 0, 0, 0, 0, '0, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, nb;
    int exp_lock [6];
    exp_lock = '{2, 2, 2, 2, 1, 2};
    fork
      compare_loop();
    join_none

    // Reset state
    #2;
    check("init_mem_ce", 32'(mem_ce), 32'(0));
    check("init_mem_addr", 32'(mem_addr), 32'(0));
    check("init_a_rvalid", 32'(a_rvalid), 32'(0));
    check("init_b_rvalid", 32'(b_rvalid), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Contention without lock: strict alternation starting with A
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 10 + i, '0, 1, 0, 0, 20 + i, '0, t1);
      if (i == 0) t0 = t1;
    end
    idle(3);
    for (int i = 0; i < 6; i++) begin
      check("cont_gnt", 32'(log_gnt[t0+i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_arv", 32'(log_arv[t0+i+2]), 32'(i % 2 == 0));
      check("cont_brv", 32'(log_brv[t0+i+2]), 32'(i % 2 == 1));
      check("cont_rdata", log_rdata[t0+i+2], (i % 2 == 0) ? pat(10 + i) : pat(20 + i));
    end

    // Single requester: write then read back
    drive(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, '0, t1);
    drive(1, 0, 0, 5, '0, 0, 0, 0, 0, '0, t2);
    idle(3);
    check("single_mem_we", 32'(log_mwe[t1+1]), 32'd1);
    check("single_arv", 32'(log_arv[t2+2]), 32'd1);
    check("single_rdata", log_rdata[t2+2], 32'hDEADBEEF);
    nb = 0;
    for (int c = t1; c <= t2 + 3; c++) nb += int'(log_brv[c]);
    check("single_no_brv", 32'(nb), 32'd0);

    // Bounded lock: B locked, A contending, MAX_HOLD = 4
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 30 + i, '0, 1, 0, 1, 40 + i, '0, t1);
      if (i == 0) t0 = t1;
    end
    idle(3);
    for (int i = 0; i < 6; i++)
      check("lock_gnt", 32'(log_gnt[t0+i]), 32'(exp_lock[i]));

    // Uncontested lock: 20 back-to-back B reads
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, '0, 1, 0, 1, 100 + i, '0, t1);
      if (i == 0) t0 = t1;
    end
    idle(3);
    for (int i = 0; i < 20; i++) begin
      check("stream_gnt", 32'(log_gnt[t0+i]), 32'd2);
      check("stream_brv", 32'(log_brv[t0+i+2]), 32'd1);
      check("stream_rdata", log_rdata[t0+i+2], pat(100 + i));
    end
    check("stream_end", 32'(log_brv[t0+22]), 32'd0);

    // Write by A followed immediately by a read of the same address by B
    drive(1, 1, 0, 9, 32'h1234, 0, 0, 0, 0, '0, t1);
    drive(0, 0, 0, 0, '0, 1, 0, 0, 9, '0, t2);
    idle(3);
    check("hazard_brv", 32'(log_brv[t2+2]), 32'd1);
    check("hazard_rdata", log_rdata[t2+2], 32'h1234);

    // Reset the cycle after a B read is accepted
    drive(0, 0, 0, 0, '0, 1, 0, 0, 50, '0, t1);
    a_valid = 0; b_valid = 0; b_lock = 0;
    check("pre_rst_ce", 32'(mem_ce), 32'd1);
    #1 rst = 1'b1;
    #1 check("rst_async_ce", 32'(mem_ce), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 0, 60, '0, 1, 0, 0, 70, '0, t2);
    idle(3);
    check("rst_no_brv_t2", 32'(log_brv[t1+2]), 32'd0);
    check("rst_no_brv_t3", 32'(log_brv[t1+3]), 32'd0);
    check("rst_prio_a", 32'(log_gnt[t2]), 32'd1);
    check("rst_after_arv", 32'(log_arv[t2+2]), 32'd1);
    check("rst_after_rdata", log_rdata[t2+2], pat(60));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
